fetch_queue: RTL and testbench

//   Decoupling buffer between instruction_fetch and the decode stage. Captures
//   {pc, instruction} pairs from fetch, presents them to decode in program order

---
 rtl/fetch_queue_if.sv | 43 ++++
 rtl/fetch_queue.sv | 87 ++++++++
 tb/tb_fetch_queue.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_if
//  Description : Handshake bundle between instruction fetch, the fetch queue
//                and decode.
//                master : producer/consumer side (fetch + decode, or a bench)
//                slave  : the fetch_queue itself
//                Signals:
//                  in_valid / in_ready / in_pc / in_instruction    fetch side
//                  out_valid / out_ready / out_pc / out_instruction decode side
//                  flush   synchronous discard of all queued entries
//                  count   current occupancy, 0..DEPTH
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_queue_if #(
    parameter int DEPTH       = 4,
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [PC_WIDTH-1:0]    in_pc;
    logic [INSTR_WIDTH-1:0] in_instruction;
    logic                   out_valid;
    logic                   out_ready;
    logic [PC_WIDTH-1:0]    out_pc;
    logic [INSTR_WIDTH-1:0] out_instruction;
    logic                   flush;
    logic [c_cnt_w-1:0]     count;

    modport master (
        output in_valid, in_pc, in_instruction, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_instruction, count
    );

    modport slave (
        input  in_valid, in_pc, in_instruction, out_ready, flush,
        output in_ready, out_valid, out_pc, out_instruction, count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : First-word-fall-through FIFO of {pc, instruction} pairs
//                between fetch and decode. Program order is preserved, a
//                flush discards every entry, and no combinational path exists
//                from the input side to the output side.
//                Ports:
//                  clock  rising-edge clock
//                  reset  asynchronous, active-high
//                  bus    fetch_queue_if.slave (handshakes, data, flush, count)
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH       = 4,
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  wire logic   clock,
    input  wire logic   reset,
    fetch_queue_if.slave bus
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(DEPTH);

    logic [PC_WIDTH-1:0]    r_pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] r_instr_mem [DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_cnt_w-1:0]     r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Full/empty come only from the registered count, so in_ready and
    // out_valid never depend on the other side's handshake in the same cycle.
    // This is what makes a full queue refuse a push even when it is being
    // popped on the same edge.
    assign w_full  = (r_count == c_full_count);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid  & ~w_full;
    assign w_pop   = bus.out_ready & ~w_empty;

    assign bus.in_ready  = ~w_full;
    assign bus.out_valid = ~w_empty;
    assign bus.count     = r_count;

    // Head entry is masked to zero while empty so stale storage never leaks.
    assign bus.out_pc          = w_empty ? '0 : r_pc_mem[r_rd_ptr];
    assign bus.out_instruction = w_empty ? '0 : r_instr_mem[r_rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (bus.flush) begin
            // Flush wins over any coincident push/pop; storage is left as is
            // because count=0 already hides it.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc_mem[r_wr_ptr]    <= bus.in_pc;
                r_instr_mem[r_wr_ptr] <= bus.in_instruction;
                r_wr_ptr              <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue. A reference occupancy
//                and a queue of expected {pc, instruction} pairs are updated
//                as stimulus is driven; entries are popped and compared when
//                the queue hands them to decode.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    fetch_queue_if #(.DEPTH(DEPTH), .PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .INSTR_WIDTH(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        ordy;
        logic        fl;
        int          exp_count;  // occupancy expected after the edge
        logic        exp_ov;     // out_valid expected after the edge
    } vec_t;

    int          n_vec;
    int          n_err;
    logic [63:0] sb [$];
    int          m_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entered and left at a falling edge: drive inputs, check the current
    // outputs against the model, advance the model, then cross one rising edge.
    task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        logic        push;
        logic        pop;
        logic [63:0] head;
        bus.in_valid       = iv;
        bus.in_pc          = pc;
        bus.in_instruction = ins;
        bus.out_ready      = ordy;
        bus.flush          = fl;
        #1;
        chk("count", 64'(bus.count), 64'(m_count));
        chk("out_valid", 64'(bus.out_valid), 64'(m_count != 0));
        chk("in_ready", 64'(bus.in_ready), 64'(m_count != DEPTH));
        head = (sb.size() != 0) ? sb[0] : 64'h0;
        chk("out_data", {bus.out_pc, bus.out_instruction}, head);
        push = iv && (m_count != DEPTH);
        pop  = ordy && (m_count != 0);
        if (fl) begin
            sb.delete();
        end else begin
            if (pop)  void'(sb.pop_front());
            if (push) sb.push_back({pc, ins});
        end
        m_count = sb.size();
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs [10];

    initial begin
        n_vec   = 0;
        n_err   = 0;
        m_count = 0;
        bus.in_valid       = 1'b0;
        bus.in_pc          = '0;
        bus.in_instruction = '0;
        bus.out_ready      = 1'b0;
        bus.flush          = 1'b0;
        rst = 1'b0;

        // Empty push, fill to full, refused push (also while popping), drain.
        vecs[0] = '{1'b1, 32'h0,  32'h00000013, 1'b0, 1'b0, 1, 1'b1};
        vecs[1] = '{1'b1, 32'h4,  32'h00100093, 1'b0, 1'b0, 2, 1'b1};
        vecs[2] = '{1'b1, 32'h8,  32'h00200113, 1'b0, 1'b0, 3, 1'b1};
        vecs[3] = '{1'b1, 32'hC,  32'h00300193, 1'b0, 1'b0, 4, 1'b1};
        vecs[4] = '{1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 4, 1'b1};
        vecs[5] = '{1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 3, 1'b1};
        vecs[6] = '{1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 2, 1'b1};
        vecs[7] = '{1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 1, 1'b1};
        vecs[8] = '{1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 0, 1'b0};
        vecs[9] = '{1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 0, 1'b0};

        // Reset held for two cycles.
        #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_data", {bus.out_pc, bus.out_instruction}, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].iv, vecs[i].pc, vecs[i].ins, vecs[i].ordy, vecs[i].fl);
            chk($sformatf("vec%0d_count", i), 64'(bus.count), 64'(vecs[i].exp_count));
            chk($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_ov));
        end

        // Concurrent push+pop at count=2; pointers wrap several times.
        cycle(1'b1, 32'h100, 32'hA0000100, 1'b0, 1'b0);
        cycle(1'b1, 32'h104, 32'hA0000104, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h108 + 32'(4 * i), 32'hA0000108 + 32'(4 * i), 1'b1, 1'b0);
            chk("concurrent_count", 64'(bus.count), 64'd2);
        end

        // Flush at count=3 with a coincident push and pop.
        cycle(1'b1, 32'h200, 32'hB0000200, 1'b0, 1'b0);
        chk("preflush_count", 64'(bus.count), 64'd3);
        cycle(1'b1, 32'h204, 32'hB0000204, 1'b1, 1'b1);
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        cycle(1'b1, 32'h300, 32'hC0000300, 1'b0, 1'b0);
        cycle(1'b0, 32'h0,   32'h0,        1'b1, 1'b0);
        cycle(1'b0, 32'h0,   32'h0,        1'b1, 1'b0);

        // Asynchronous reset between edges with three entries queued.
        cycle(1'b1, 32'h400, 32'hD0000400, 1'b0, 1'b0);
        cycle(1'b1, 32'h404, 32'hD0000404, 1'b0, 1'b0);
        cycle(1'b1, 32'h408, 32'hD0000408, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        chk("prereset_count", 64'(bus.count), 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("async_count", 64'(bus.count), 64'd0);
        chk("async_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_in_ready", 64'(bus.in_ready), 64'd1);
        chk("async_out_data", {bus.out_pc, bus.out_instruction}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        m_count = 0;
        cycle(1'b1, 32'h500, 32'hE0000500, 1'b0, 1'b0);
        cycle(1'b1, 32'h504, 32'hE0000504, 1'b1, 1'b0);
        cycle(1'b0, 32'h0,   32'h0,        1'b1, 1'b0);
        cycle(1'b0, 32'h0,   32'h0,        1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
